// File: rtl/shifter_stage.sv
// shifter_stage: ARM7 operand-2 barrel shifter feeding the ALU, with valid/ready handshake.
// Optional macro SHIFTER_STAGE_FAST_REG_EN: register shifts sample rs_val at accept (latency 1).
//
// state   | meaning
// IDLE    | can accept a new op when the output register is free
// RS_WAIT | register-shift op latched; Rs arrives on rs_val this cycle
module shifter_stage #(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_a,
    input  logic             in_imm_form,
    input  logic [7:0]       in_imm8,
    input  logic [3:0]       in_rot,
    input  logic [1:0]       in_shift_type,
    input  logic             in_shift_by_reg,
    input  logic [4:0]       in_shift_imm,
    input  logic [31:0]      in_rm,
    input  logic             in_c,
    input  logic [7:0]       rs_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_shifter_c
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] d;
        d = {v, v} >> n;
        return d[31:0];
    endfunction

    // Result packing for all shifter helpers: {carry, value}.
    function automatic logic [32:0] shift_imm(
        input logic [1:0]  typ,
        input logic [4:0]  n,
        input logic [31:0] rm,
        input logic        c
    );
        logic [32:0] r;
        logic [4:0]  lsl_idx;
        logic [4:0]  nm1;
        lsl_idx = 5'd0 - n;
        nm1     = n - 5'd1;
        r       = {c, rm};
        case (typ)
            SH_LSL: begin
                if (n != 5'd0) r = {rm[lsl_idx], rm << n};
            end
            SH_LSR: begin
                r = (n == 5'd0) ? {rm[31], 32'd0} : {rm[nm1], rm >> n};
            end
            SH_ASR: begin
                r = (n == 5'd0) ? {rm[31], {32{rm[31]}}}
                                : {rm[nm1], 32'($signed(rm) >>> n)};
            end
            default: begin
                // n==0 is RRX: rotate right by one through the carry flag.
                r = (n == 5'd0) ? {rm[0], c, rm[31:1]} : {rm[nm1], ror32(rm, n)};
            end
        endcase
        return r;
    endfunction

    function automatic logic [32:0] shift_reg(
        input logic [1:0]  typ,
        input logic [7:0]  s,
        input logic [31:0] rm,
        input logic        c
    );
        logic [32:0] r;
        logic        big;
        logic        exact;
        big   = (s[7:5] != 3'd0);
        exact = (s == 8'd32);
        // Amounts 1..31 behave exactly like the immediate encoding.
        r = shift_imm(typ, s[4:0], rm, c);
        if (s == 8'd0) begin
            r = {c, rm};
        end else begin
            case (typ)
                SH_LSL: begin
                    if (big) r = exact ? {rm[0], 32'd0} : 33'd0;
                end
                SH_LSR: begin
                    if (big) r = exact ? {rm[31], 32'd0} : 33'd0;
                end
                SH_ASR: begin
                    if (big) r = {rm[31], {32{rm[31]}}};
                end
                default: begin
                    if (s[4:0] == 5'd0) r = {rm[31], rm};
                end
            endcase
        end
        return r;
    endfunction

    function automatic logic [32:0] operand2(
        input logic        imm_form,
        input logic [7:0]  imm8,
        input logic [3:0]  rot,
        input logic [1:0]  typ,
        input logic        by_reg,
        input logic [4:0]  sh_amt,
        input logic [31:0] rm,
        input logic        c,
        input logic [7:0]  s
    );
        logic [31:0] imm_b;
        logic [32:0] r;
        imm_b = ror32({24'd0, imm8}, {rot, 1'b0});
        if (imm_form) begin
            r = {(rot == 4'd0) ? c : imm_b[31], imm_b};
        end else if (by_reg) begin
            r = shift_reg(typ, s, rm, c);
        end else begin
            r = shift_imm(typ, sh_amt, rm, c);
        end
        return r;
    endfunction

    logic        accept;
    logic [32:0] new_res;

    assign accept  = in_valid && in_ready;
    assign new_res = operand2(in_imm_form, in_imm8, in_rot, in_shift_type, in_shift_by_reg,
                              in_shift_imm, in_rm, in_c, rs_val);

`ifdef SHIFTER_STAGE_FAST_REG_EN

    assign in_ready = (!out_valid || out_ready) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_a         <= '0;
            out_b         <= '0;
            out_shifter_c <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_tag       <= in_tag;
            out_a         <= in_a;
            out_b         <= new_res[31:0];
            out_shifter_c <= new_res[32];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`else

    typedef enum logic {
        IDLE,
        RS_WAIT
    } state_t;

    state_t            state;
    logic [TAG_W-1:0]  hold_tag;
    logic [31:0]       hold_a;
    logic              hold_imm_form;
    logic [7:0]        hold_imm8;
    logic [3:0]        hold_rot;
    logic [1:0]        hold_type;
    logic              hold_by_reg;
    logic [4:0]        hold_shift_imm;
    logic [31:0]       hold_rm;
    logic              hold_c;
    logic [32:0]       hold_res;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;

    // Carry comes from the accept-time CPSR copy; only Rs is taken live.
    assign hold_res = operand2(hold_imm_form, hold_imm8, hold_rot, hold_type, hold_by_reg,
                               hold_shift_imm, hold_rm, hold_c, rs_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            out_valid      <= 1'b0;
            out_tag        <= '0;
            out_a          <= '0;
            out_b          <= '0;
            out_shifter_c  <= 1'b0;
            hold_tag       <= '0;
            hold_a         <= '0;
            hold_imm_form  <= 1'b0;
            hold_imm8      <= '0;
            hold_rot       <= '0;
            hold_type      <= '0;
            hold_by_reg    <= 1'b0;
            hold_shift_imm <= '0;
            hold_rm        <= '0;
            hold_c         <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_tag       <= in_tag;
                        hold_a         <= in_a;
                        hold_imm_form  <= in_imm_form;
                        hold_imm8      <= in_imm8;
                        hold_rot       <= in_rot;
                        hold_type      <= in_shift_type;
                        hold_by_reg    <= in_shift_by_reg;
                        hold_shift_imm <= in_shift_imm;
                        hold_rm        <= in_rm;
                        hold_c         <= in_c;
                        if (!in_imm_form && in_shift_by_reg) begin
                            state     <= RS_WAIT;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid     <= 1'b1;
                            out_tag       <= in_tag;
                            out_a         <= in_a;
                            out_b         <= new_res[31:0];
                            out_shifter_c <= new_res[32];
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                RS_WAIT: begin
                    // The output was free on entry, so this always completes.
                    state         <= IDLE;
                    out_valid     <= 1'b1;
                    out_tag       <= hold_tag;
                    out_a         <= hold_a;
                    out_b         <= hold_res[31:0];
                    out_shifter_c <= hold_res[32];
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_shifter_stage.sv
// tb_shifter_stage: table vectors, hand-written corner sequences and a random scoreboard run.
module tb_shifter_stage;
    localparam int TAG_W = 8;
`ifdef SHIFTER_STAGE_FAST_REG_EN
    localparam int REG_LAT = 1;
`else
    localparam int REG_LAT = 2;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_a;
    logic             in_imm_form;
    logic [7:0]       in_imm8;
    logic [3:0]       in_rot;
    logic [1:0]       in_shift_type;
    logic             in_shift_by_reg;
    logic [4:0]       in_shift_imm;
    logic [31:0]      in_rm;
    logic             in_c;
    logic [7:0]       rs_val;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    logic             out_shifter_c;

    shifter_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_a(in_a),
        .in_imm_form(in_imm_form), .in_imm8(in_imm8), .in_rot(in_rot),
        .in_shift_type(in_shift_type), .in_shift_by_reg(in_shift_by_reg),
        .in_shift_imm(in_shift_imm), .in_rm(in_rm), .in_c(in_c), .rs_val(rs_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_a(out_a), .out_b(out_b), .out_shifter_c(out_shifter_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        imm_form;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [1:0]  typ;
        logic        by_reg;
        logic [4:0]  sh;
        logic [31:0] rm;
        logic        c;
        logic [7:0]  s;
        logic [31:0] exp_b;
        logic        exp_c;
    } vec_t;

    typedef struct {
        logic [31:0]      b;
        logic             c;
        logic [31:0]      a;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift one bit at a time, carry is the last bit pushed out.
    function automatic logic [32:0] model_shift(input logic [1:0] typ, input int amt,
                                                input logic [31:0] rm, input logic c);
        logic [31:0] v;
        logic        co;
        v  = rm;
        co = c;
        for (int i = 0; i < amt; i++) begin
            case (typ)
                2'd0: begin co = v[31]; v = v << 1; end
                2'd1: begin co = v[0];  v = v >> 1; end
                2'd2: begin co = v[0];  v = {v[31], v[31:1]}; end
                default: begin co = v[0]; v = {v[0], v[31:1]}; end
            endcase
        end
        return {co, v};
    endfunction

    function automatic logic [32:0] model_op(input vec_t v);
        logic [31:0] b;
        if (v.imm_form) begin
            b = {24'd0, v.imm8};
            for (int i = 0; i < 2 * int'(v.rot); i++) b = {b[0], b[31:1]};
            return {(v.rot == 4'd0) ? v.c : b[31], b};
        end else if (v.by_reg) begin
            return model_shift(v.typ, int'(v.s), v.rm, v.c);
        end else if (v.sh != 5'd0) begin
            return model_shift(v.typ, int'(v.sh), v.rm, v.c);
        end else if (v.typ == 2'd0) begin
            return {v.c, v.rm};
        end else if (v.typ == 2'd3) begin
            return {v.rm[0], v.c, v.rm[31:1]};
        end else begin
            return model_shift(v.typ, 32, v.rm, v.c);
        end
    endfunction

    function automatic vec_t mk(input logic imm_form, input logic [7:0] imm8, input logic [3:0] rot,
                                input logic [1:0] typ, input logic by_reg, input logic [4:0] sh,
                                input logic [31:0] rm, input logic c, input logic [7:0] s,
                                input logic [31:0] exp_b, input logic exp_c);
        vec_t v;
        v.imm_form = imm_form; v.imm8 = imm8; v.rot = rot; v.typ = typ; v.by_reg = by_reg;
        v.sh = sh; v.rm = rm; v.c = c; v.s = s; v.exp_b = exp_b; v.exp_c = exp_c;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic [7:0] picks [8];
        picks = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd0};
        v.imm_form = ($urandom_range(0, 3) == 0);
        v.imm8     = 8'($urandom);
        v.rot      = 4'($urandom);
        v.typ      = 2'($urandom);
        v.by_reg   = 1'($urandom);
        v.sh       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        v.rm       = ($urandom_range(0, 4) == 0) ? 32'h8000_0001 : $urandom;
        v.c        = 1'($urandom);
        v.s        = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 6)] : 8'($urandom);
        v.exp_b    = '0;
        v.exp_c    = 1'b0;
        return v;
    endfunction

    task automatic drive_op(input vec_t v, input logic [TAG_W-1:0] tag, input logic [31:0] a);
        in_imm_form = v.imm_form; in_imm8 = v.imm8; in_rot = v.rot;
        in_shift_type = v.typ; in_shift_by_reg = v.by_reg; in_shift_imm = v.sh;
        in_rm = v.rm; in_c = v.c; in_tag = tag; in_a = a;
    endtask

    // Single op with out_ready high; checks latency, bubble and result against the table.
    task automatic do_vec(input vec_t v, input int idx);
        logic        two;
        logic [31:0] a;
        int          lat;
        two = !v.imm_form && v.by_reg;
        a   = $urandom;
        drive_op(v, TAG_W'(idx), a);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rs_val    = (two && REG_LAT == 2) ? ~v.s : v.s;
        #1;
        check($sformatf("vec%0d_accept_ready", idx), in_ready, 1);
        step();
        in_valid = 1'b0;
        in_imm_form = 1'b0; in_rm = 32'h0; in_c = ~v.c;
        rs_val = v.s;
        if (two && REG_LAT == 2) check($sformatf("vec%0d_rs_wait_ready", idx), in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 6) begin
            step();
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), lat, two ? REG_LAT : 1);
        check($sformatf("vec%0d_b", idx), out_b, v.exp_b);
        check($sformatf("vec%0d_c", idx), out_shifter_c, v.exp_c);
        check($sformatf("vec%0d_tag", idx), out_tag, TAG_W'(idx));
        check($sformatf("vec%0d_a", idx), out_a, a);
    endtask

    vec_t vecs [19];
    exp_t sb [$];

    initial begin
        vec_t        va, vb, vc, vd, cur;
        logic [32:0] r;
        logic [7:0]  rs_hold;
        logic        rs_hold_valid;
        logic        prev_stall;
        logic [31:0] prev_b;
        logic [7:0]  prev_tag;
        logic [7:0]  cur_tag;
        logic [31:0] cur_a;
        exp_t        e;
        int          n_cyc;

        vecs[0]  = mk(1, 8'hFF, 4'd4,  2'd0, 1, 5'd0, 32'h0,         0, 8'd0,   32'hFF00_0000, 1);
        vecs[1]  = mk(1, 8'h5A, 4'd0,  2'd0, 0, 5'd0, 32'h0,         1, 8'd0,   32'h0000_005A, 1);
        vecs[2]  = mk(1, 8'h01, 4'd15, 2'd0, 0, 5'd0, 32'h0,         0, 8'd0,   32'h0000_0004, 0);
        vecs[3]  = mk(0, 8'h00, 4'd0,  2'd1, 0, 5'd0, 32'h8000_0001, 1, 8'd0,   32'h0000_0000, 1);
        vecs[4]  = mk(0, 8'h00, 4'd0,  2'd2, 0, 5'd0, 32'h8000_0001, 1, 8'd0,   32'hFFFF_FFFF, 1);
        vecs[5]  = mk(0, 8'h00, 4'd0,  2'd3, 0, 5'd0, 32'h8000_0001, 1, 8'd0,   32'hC000_0000, 1);
        vecs[6]  = mk(0, 8'h00, 4'd0,  2'd0, 0, 5'd0, 32'h8000_0001, 1, 8'd0,   32'h8000_0001, 1);
        vecs[7]  = mk(0, 8'h00, 4'd0,  2'd0, 0, 5'd1, 32'h8000_0001, 0, 8'd0,   32'h0000_0002, 1);
        vecs[8]  = mk(0, 8'h00, 4'd0,  2'd2, 0, 5'd4, 32'h8000_0010, 0, 8'd0,   32'hF800_0001, 0);
        vecs[9]  = mk(0, 8'h00, 4'd0,  2'd3, 0, 5'd8, 32'h1234_5678, 1, 8'd0,   32'h7812_3456, 0);
        vecs[10] = mk(0, 8'h00, 4'd0,  2'd0, 1, 5'd0, 32'h0000_0003, 0, 8'd32,  32'h0000_0000, 1);
        vecs[11] = mk(0, 8'h00, 4'd0,  2'd0, 1, 5'd0, 32'h0000_0003, 1, 8'd33,  32'h0000_0000, 0);
        vecs[12] = mk(0, 8'h00, 4'd0,  2'd0, 1, 5'd0, 32'h0000_0003, 1, 8'd0,   32'h0000_0003, 1);
        vecs[13] = mk(0, 8'h00, 4'd0,  2'd0, 1, 5'd0, 32'h0000_0003, 0, 8'd0,   32'h0000_0003, 0);
        vecs[14] = mk(0, 8'h00, 4'd0,  2'd1, 1, 5'd0, 32'h8000_0000, 0, 8'd32,  32'h0000_0000, 1);
        vecs[15] = mk(0, 8'h00, 4'd0,  2'd2, 1, 5'd0, 32'h8000_0000, 0, 8'd200, 32'hFFFF_FFFF, 1);
        vecs[16] = mk(0, 8'h00, 4'd0,  2'd3, 1, 5'd0, 32'h8000_0001, 0, 8'd32,  32'h8000_0001, 1);
        vecs[17] = mk(0, 8'h00, 4'd0,  2'd3, 1, 5'd0, 32'h0000_00F1, 1, 8'd36,  32'h1000_000F, 0);
        vecs[18] = mk(0, 8'h00, 4'd0,  2'd1, 1, 5'd0, 32'h0000_0001, 0, 8'd1,   32'h0000_0000, 1);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rs_val = 8'h0;
        drive_op(vecs[0], '0, '0);
        #1 rst = 1'b1;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_b", out_b, 0);
        check("reset_out_a", out_a, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_out_c", out_shifter_c, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 19; i++) do_vec(vecs[i], i);

        // Backpressure: result held for three cycles while the next op waits.
        va = mk(1, 8'h12, 4'd1, 2'd0, 0, 5'd0, 32'h0, 0, 8'd0, 32'h0, 0);
        vb = mk(0, 8'h00, 4'd0, 2'd0, 0, 5'd4, 32'h0000_000F, 0, 8'd0, 32'h0, 0);
        drive_op(va, 8'hA1, 32'h1111_1111);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive_op(vb, 8'hB2, 32'h2222_2222);
        r = model_op(va);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold_b_%0d", k), out_b, r[31:0]);
            check($sformatf("bp_hold_tag_%0d", k), out_tag, 8'hA1);
            check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        r = model_op(vb);
        check("bp_next_valid", out_valid, 1);
        check("bp_next_b", out_b, r[31:0]);
        check("bp_next_c", out_shifter_c, r[32]);
        check("bp_next_tag", out_tag, 8'hB2);
        step();

        // Flush while a register-shift op is in flight.
        vc = mk(0, 8'h00, 4'd0, 2'd0, 1, 5'd0, 32'h0000_0003, 0, 8'd1, 32'h0, 0);
        vd = mk(1, 8'h3C, 4'd2, 2'd0, 0, 5'd0, 32'h0, 1, 8'd0, 32'h0, 0);
        drive_op(vc, 8'hC3, 32'h3333_3333);
        rs_val = 8'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (REG_LAT == 2) check("flush_rs_wait_ready", in_ready, 0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_idle_ready", in_ready, 1);
        drive_op(vd, 8'hD4, 32'h4444_4444);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        r = model_op(vd);
        check("flush_next_valid", out_valid, 1);
        check("flush_next_b", out_b, r[31:0]);
        check("flush_next_tag", out_tag, 8'hD4);
        step();
        check("flush_no_ghost", out_valid, 0);

        // Asynchronous reset between edges while a register shift is pending.
        drive_op(vc, 8'hE5, 32'h5555_5555);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_b", out_b, 0);
        check("arst_out_a", out_a, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_out_c", out_shifter_c, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        step();
        check("arst_no_result", out_valid, 0);

        // Random traffic against the reference model through a scoreboard.
        cur = rand_vec(); cur_tag = 8'($urandom); cur_a = $urandom;
        rs_hold_valid = 1'b0; rs_hold = 8'h0;
        prev_stall = 1'b0; prev_b = '0; prev_tag = '0;
        n_cyc = 2000;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            if (cyc >= n_cyc - 10) begin
                out_ready = 1'b1; flush = 1'b0; in_valid = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 40) == 0);
                in_valid  = ($urandom_range(0, 4) != 0);
            end
            drive_op(cur, cur_tag, cur_a);
            if (rs_hold_valid) rs_val = rs_hold;
            else rs_val = (REG_LAT == 2) ? 8'($urandom) : cur.s;
            rs_hold_valid = 1'b0;
            #3;
            if (prev_stall) begin
                check("rand_hold_valid", out_valid, 1);
                check("rand_hold_b", out_b, prev_b);
                check("rand_hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_sb_nonempty", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("rand_b", out_b, e.b);
                    check("rand_c", out_shifter_c, e.c);
                    check("rand_a", out_a, e.a);
                    check("rand_tag", out_tag, e.tag);
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_b = out_b;
            prev_tag = out_tag;
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                r = model_op(cur);
                e.b = r[31:0]; e.c = r[32]; e.a = cur_a; e.tag = cur_tag;
                sb.push_back(e);
                if (!cur.imm_form && cur.by_reg && REG_LAT == 2) begin
                    rs_hold_valid = 1'b1;
                    rs_hold = cur.s;
                end
                cur = rand_vec(); cur_tag = 8'($urandom); cur_a = $urandom;
            end
            step();
        end
        check("rand_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
